grant_burst_ctrl: RTL and testbench
===================================

# grant_burst_ctrl

Downstream consumer of the loop arbiter's one-hot `grant`. It locks onto the granted requester and holds `arb_en` low while it moves that requester's burst, one beat per cycle, through a registered valid/ready output stage. It releases the arbiter once the last beat has been taken. A burst ends on the source's `last` flag or is truncated at `MAX_BEATS`.

## Interface
- `N`, 7: number of requesters; matches the arbiter `req`/`grant` width.
- `DW`, 8: data width per beat.
- `MAX_BEATS`, 8: maximum beats per burst (≥1).
- `IDW`, `$clog2(N)`: width of `out_id` (derived).

- `clk`  in  1  single clock; everything on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `grant`  in  N  one-hot grant from arbiter.
- `arb_en`  out  1  arbiter enable. Equals (state==IDLE) && !rst.
- `src_valid`  in  N  per-source beat valid.
- `src_data`  in  N*DW  per-source data; source i occupies bits [i*DW +: DW].
- `src_last`  in  N  per-source end-of-burst flag.
- `src_ready`  out  N  per-source ready; at most one bit set.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  DW  output beat data.
- `out_last`  out  1  final beat of burst.
- `out_id`  out  IDW  index of the owning requester.
- `out_ready`  in  1  downstream ready.
- `busy`  out  1  state != IDLE.
- `err_multi`  out  1  one-cycle pulse when `grant` is not one-hot (≥2 bits set) while in IDLE.

## Operation
- **FSM IDLE / XFER / DRAIN.** Reset forces IDLE, beat counter 0, and the output register empty.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_last`=0, `out_id`=0, `src_ready`=0, `busy`=0, `err_multi`=0, `arb_en`=0. `arb_en` goes to 1 in the first cycle with `rst` low.
- **IDLE**
  - `arb_en`=1 and `src_ready`=0.
  - `grant` is sampled every edge.
  - Exactly one bit i set: capture `id`=i, clear the counter, go to XFER.
  - `grant`=0: stay in IDLE.
  - Multi-hot `grant`: stay in IDLE and pulse `err_multi`. Nothing is captured.
- **XFER**
  - `arb_en`=0. `grant` is ignored.
  - `src_ready[id]` = !`out_valid` || `out_ready`. All other `src_ready` bits are 0.
  - On `src_valid[id]` && `src_ready[id]`:
    - load `out_data`=`src_data[id]` and `out_id`=`id`, and set `out_valid`;
    - set `out_last` = `src_last[id]` || (cnt == `MAX_BEATS`-1);
    - increment the counter.
  - If that beat's `out_last`=1, go to DRAIN.
  - On `out_valid` && `out_ready` with no new load, clear `out_valid`.
- **DRAIN**
  - `src_ready`=0.
  - On `out_valid` && `out_ready`: clear `out_valid` and `out_last`, go to IDLE.
- **Truncation:** source beats left after the `MAX_BEATS` cut stay at the source and are moved in a later grant. The source's `last` is not altered.
- **Counter:** ceil(log2(`MAX_BEATS`+1)) bits. It never exceeds `MAX_BEATS`-1 at comparison.
- **Reset during XFER/DRAIN:** the burst is abandoned. Reset values apply the cycle after the reset edge, and any beat pending in the output register is dropped.

## Timing
- **Grant to ownership:** grant seen at edge E → `busy`=1, `arb_en`=0, and `src_ready[id]` possible in cycle E+1.
- **Beat latency:** a beat accepted at edge E appears on `out_*` after E (1 cycle).
- **Throughput:** 1 beat/cycle while `out_ready`=1. Load and unload may happen on the same edge.
- **Stall rule:** while `out_valid`=1 and `out_ready`=0, `out_data`/`out_last`/`out_id` are stable and `src_ready`=0.
- **Release:** last beat handshaken at edge E → IDLE, and `arb_en`=1 in cycle E+1. The next grant is capturable at edge E+1.
- **Minimum occupancy:** 1-beat burst with `out_ready`=1 takes 3 cycles grant-to-grant: capture, XFER load, DRAIN unload.
- **`err_multi`:** combinationally qualified and registered, so it is high the cycle after the offending edge, for exactly one cycle.

## Test plan
- **Reset:** hold `rst` 3 cycles with random `grant`/`src_*` → all outputs at reset values. `arb_en`=0 during reset, 1 on the first cycle after.
- **Basic burst:** `grant`=7'b000_1000. Source 3 offers 0x11, 0x22, 0x33 (last on 0x33); `out_ready`=1.
  - Outputs are 0x11, 0x22, 0x33 on consecutive cycles with `out_id`=3.
  - `out_last` is set only on 0x33.
  - `arb_en` is low from the cycle after capture until the cycle after the 0x33 handshake.
  - `src_ready` bits other than bit 3 stay 0.
- **Backpressure:** same burst with `out_ready` pattern 1,0,0,1,0,1,1 → exactly 3 beats, in order, no duplicates. `out_data` is stable on stall cycles, and `src_ready[3]`=0 while stalled.
- **Truncation:** `MAX_BEATS`=8. Source 0 holds `src_valid`=1 with `last`=0 for 10 beats (0..9).
  - Beats 0..7 are output, with `out_last`=1 on beat 7.
  - Beats 8 and 9 remain unconsumed.
  - Re-grant of source 0 moves 8 and 9.
- **Illegal grant:** `grant`=7'b100_0001 in IDLE → `err_multi` is 1 for one cycle. The block stays in IDLE, `arb_en` stays 1, and `src_ready`=0. Changing `grant` to 7'b010_0000 during XFER has no effect on `out_id`.
- **Mid-burst reset:** assert `rst` after 2 of 4 beats have been accepted → next cycle all outputs are at reset values and the FSM is in IDLE. After release, a fresh grant to source 5 runs a correct burst with `out_id`=5.

Source files
------------

// File: rtl/grant_burst_ctrl.sv
// rtl/grant_burst_ctrl.sv - locks onto a one-hot arbiter grant and moves that source's burst through a registered output stage
module grant_burst_ctrl #(
  parameter int N         = 7,
  parameter int DW        = 8,
  parameter int MAX_BEATS = 8,
  parameter int IDW       = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    grant,
  output logic            arb_en,
  input  logic [N-1:0]    src_valid,
  input  logic [N*DW-1:0] src_data,
  input  logic [N-1:0]    src_last,
  output logic [N-1:0]    src_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [IDW-1:0]  out_id,
  input  logic            out_ready,
  output logic            busy,
  output logic            err_multi
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] XFER  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] id;
  logic [CW-1:0]  cnt;

  logic [IDW-1:0] grant_idx;
  logic           grant_one;
  logic           grant_multi;
  logic           sel_valid;
  logic           sel_last;
  logic [DW-1:0]  sel_data;
  logic           own_ready;
  logic           load;
  logic           beat_last;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
    grant_one   = (grant != '0) && ((grant & (grant - N'(1))) == '0);
    grant_multi = (grant != '0) && !grant_one;
  end

  // Mux the owning source's beat by comparing against each index, keeping every select in range.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (id == IDW'(i)) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[i*DW +: DW];
      end
    end
  end

  assign own_ready = (state == XFER) && (!out_valid || out_ready);
  assign load      = own_ready && sel_valid;
  assign beat_last = sel_last || (cnt == CW'(MAX_BEATS - 1));

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < N; i++) begin
      src_ready[i] = own_ready && (id == IDW'(i));
    end
  end

  assign arb_en = (state == IDLE) && !rst;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      id        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
      err_multi <= 1'b0;
    end else begin
      err_multi <= 1'b0;
      case (state)
        IDLE: begin
          err_multi <= grant_multi;
          if (grant_one) begin
            id    <= grant_idx;
            cnt   <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (load) begin
            out_data  <= sel_data;
            out_id    <= id;
            out_valid <= 1'b1;
            out_last  <= beat_last;
            cnt       <= cnt + CW'(1);
            if (beat_last) state <= DRAIN;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// tb/tb_grant_burst_ctrl.sv - randomized bench for grant_burst_ctrl against a burst-level reference model
module tb_grant_burst_ctrl;

  localparam int N         = 7;
  localparam int DW        = 8;
  localparam int MAX_BEATS = 8;
  localparam int IDW       = $clog2(N);
  localparam int CYCLES    = 4000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    grant;
  logic            arb_en;
  logic [N-1:0]    src_valid;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_last;
  logic [N-1:0]    src_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [IDW-1:0]  out_id;
  logic            out_ready;
  logic            busy;
  logic            err_multi;

  always #5 clk = ~clk;

  grant_burst_ctrl #(.N(N), .DW(DW), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant),
    .arb_en    (arb_en),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_ready (src_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy),
    .err_multi (err_multi)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Each source holds a queue of pending beats {last, data}.
  logic [DW:0] srcq [N][$];

  bit          m_idle;
  int          m_owner;
  int          m_left;
  bit          m_pend;
  logic [DW-1:0] m_data;
  bit          m_last;
  int          m_id;
  bit          m_err;
  int          rst_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int burst_len(input int s);
    for (int k = 0; k < MAX_BEATS; k++) begin
      if (srcq[s][k][DW]) return k + 1;
    end
    return MAX_BEATS;
  endfunction

  task automatic refill();
    for (int i = 0; i < N; i++) begin
      while (srcq[i].size() < 16) begin
        int len;
        len = $urandom_range(1, 12);
        for (int b = 0; b < len; b++) begin
          logic [DW:0] beat;
          beat[DW-1:0] = DW'($urandom);
          beat[DW]     = (b == len - 1);
          srcq[i].push_back(beat);
        end
      end
    end
  endtask

  initial begin
    logic [N-1:0] exp_rdy;
    bit           take;
    bit           load;
    int           r;
    int           a;
    int           b;

    m_idle = 1; m_owner = 0; m_left = 0; m_pend = 0;
    m_data = '0; m_last = 0; m_id = 0; m_err = 0; rst_hold = 0;
    rst = 1'b1; grant = '0; src_valid = '0; src_data = '0; src_last = '0; out_ready = 1'b0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        check("out_valid", 32'(out_valid), 32'(m_pend));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_last",  32'(out_last),  32'(m_last));
        check("out_id",    32'(out_id),    32'(m_id));
        check("busy",      32'(busy),      32'(!m_idle));
        check("err_multi", 32'(err_multi), 32'(m_err));
      end

      refill();
      if (cyc < 3) rst = 1'b1;
      else if (rst_hold > 0) begin rst = 1'b1; rst_hold--; end
      else if ($urandom_range(0, 299) == 0) begin rst = 1'b1; rst_hold = $urandom_range(0, 2); end
      else rst = 1'b0;

      r = $urandom_range(0, 9);
      if (r < 5) grant = N'(1) << $urandom_range(0, N - 1);
      else if (r < 7) begin
        a = $urandom_range(0, N - 1);
        b = (a + $urandom_range(1, N - 1)) % N;
        grant = (N'(1) << a) | (N'(1) << b);
      end else grant = '0;

      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        src_valid[i]          = ($urandom_range(0, 3) != 0);
        src_data[i*DW +: DW]  = srcq[i][0][DW-1:0];
        src_last[i]           = srcq[i][0][DW];
      end

      #1;
      exp_rdy = '0;
      if (!m_idle && m_left > 0 && (!m_pend || out_ready)) exp_rdy[m_owner] = 1'b1;
      if (cyc > 0) begin
        check("arb_en",    32'(arb_en),    32'(m_idle && !rst));
        check("src_ready", 32'(src_ready), 32'(exp_rdy));
      end

      if (rst) begin
        m_idle = 1; m_left = 0; m_pend = 0; m_data = '0; m_last = 0; m_id = 0; m_err = 0;
      end else if (m_idle) begin
        m_err = ($countones(grant) >= 2);
        if ($countones(grant) == 1) begin
          for (int i = 0; i < N; i++) if (grant[i]) m_owner = i;
          m_left = burst_len(m_owner);
          m_idle = 0;
        end
      end else begin
        m_err = 0;
        take  = m_pend && out_ready;
        load  = exp_rdy[m_owner] && src_valid[m_owner];
        if (load) begin
          m_data = srcq[m_owner][0][DW-1:0];
          void'(srcq[m_owner].pop_front());
          m_id   = m_owner;
          m_last = (m_left == 1);
          m_pend = 1;
          m_left--;
        end else if (take) begin
          m_pend = 0;
          if (m_last) begin
            m_last = 0;
            m_idle = 1;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
